// File: rtl/adventure_game.sv
// Text-adventure room controller: Moore FSM over seven rooms plus a sword flag.
// Optional macro ROOM_DEBUG_EN exposes room_id and has_sword.
module adventure_game (
  input  logic       clk,
  input  logic       reset,
  input  logic       n,
  input  logic       s,
  input  logic       e,
  input  logic       w,
  output logic       d,
  output logic       win
`ifdef ROOM_DEBUG_EN
  ,
  output logic [2:0] room_id,
  output logic       has_sword
`endif
);

  typedef enum logic [2:0] {
    CAVE      = 3'd0,
    TUNNEL    = 3'd1,
    RIVER     = 3'd2,
    STASH     = 3'd3,
    DEN       = 3'd4,
    VAULT     = 3'd5,
    GRAVEYARD = 3'd6
  } room_t;

  room_t room, room_nxt;
  logic  sword;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      room  <= CAVE;
      sword <= 1'b0;
    end else begin
      room <= room_nxt;
      if (room == STASH) sword <= 1'b1;
    end
  end

  // Exits checked in n > s > e > w order; unlisted directions never match.
  always_comb begin
    room_nxt = room;
    case (room)
      CAVE:      if (e) room_nxt = TUNNEL;
      TUNNEL: begin
        if (s)      room_nxt = RIVER;
        else if (w) room_nxt = CAVE;
      end
      RIVER: begin
        if (n)      room_nxt = TUNNEL;
        else if (e) room_nxt = DEN;
        else if (w) room_nxt = STASH;
      end
      STASH:     if (e) room_nxt = RIVER;
      DEN:       room_nxt = sword ? VAULT : GRAVEYARD;
      VAULT:     room_nxt = VAULT;
      GRAVEYARD: room_nxt = GRAVEYARD;
      default:   room_nxt = CAVE;
    endcase
  end

  assign d   = (room == GRAVEYARD);
  assign win = (room == VAULT);

`ifdef ROOM_DEBUG_EN
  assign room_id   = room;
  assign has_sword = sword;
`endif

endmodule

// File: tb/tb_adventure_game.sv
// Bench for adventure_game: scripted vector table, async-reset check, and
// randomized walks compared against an exit-table reference model.
module tb_adventure_game;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic n = 1'b0, s = 1'b0, e = 1'b0, w = 1'b0;
  logic d, win;
`ifdef ROOM_DEBUG_EN
  logic [2:0] room_id;
  logic       has_sword;
`endif

  adventure_game dut (
    .clk(clk), .reset(reset), .n(n), .s(s), .e(e), .w(w), .d(d), .win(win)
`ifdef ROOM_DEBUG_EN
    , .room_id(room_id), .has_sword(has_sword)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic act_d, input logic act_win,
                       input logic exp_d, input logic exp_win);
    n_checks++;
    if (act_d !== exp_d || act_win !== exp_win) begin
      n_fail++;
      $display("FAIL %s: got d=%b win=%b, expected d=%b win=%b",
               name, act_d, act_win, exp_d, exp_win);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    {n, s, e, w} = 4'b0000;
    #50;
    reset = 1'b0;
  endtask

  // dv = {n,s,e,w}
  task automatic step(input logic [3:0] dv);
    @(negedge clk);
    {n, s, e, w} = dv;
    @(posedge clk);
    #1;
  endtask

  // Reference model: room codes per the room list, exits by direction index n,s,e,w.
  int exit_tbl [7][4];
  int m_room;
  bit m_sword;

  function automatic int model_next(input int room, input bit sword, input logic [3:0] dv);
    if (room == 4) return sword ? 5 : 6;
    if (room == 5 || room == 6) return room;
    for (int i = 0; i < 4; i++)
      if (dv[3-i] && exit_tbl[room][i] >= 0) return exit_tbl[room][i];
    return room;
  endfunction

  typedef struct {
    bit         rst;
    logic [3:0] dirs;
    logic       exp_d;
    logic       exp_win;
    string      name;
  } vec_t;

  vec_t vecs[$];

  function automatic void addv(input bit r, input logic [3:0] dv, input logic ed,
                               input logic ew, input string nm);
    vec_t v;
    v.rst = r; v.dirs = dv; v.exp_d = ed; v.exp_win = ew; v.name = nm;
    vecs.push_back(v);
  endfunction

  initial begin
    for (int r = 0; r < 7; r++)
      for (int i = 0; i < 4; i++) exit_tbl[r][i] = -1;
    exit_tbl[0][2] = 1;
    exit_tbl[1][3] = 0; exit_tbl[1][1] = 2;
    exit_tbl[2][0] = 1; exit_tbl[2][3] = 3; exit_tbl[2][2] = 4;
    exit_tbl[3][2] = 2;

    // Reset and idle
    addv(1, 4'b0000, 0, 0, "reset");
    for (int i = 0; i < 10; i++) addv(0, 4'b0000, 0, 0, "idle");
    // Sword path to vault
    addv(1, 4'b0000, 0, 0, "reset_a");
    addv(0, 4'b0010, 0, 0, "a_tunnel");
    addv(0, 4'b0100, 0, 0, "a_river");
    addv(0, 4'b0001, 0, 0, "a_stash");
    addv(0, 4'b0010, 0, 0, "a_river2");
    addv(0, 4'b0010, 0, 0, "a_den");
    addv(0, 4'b0010, 0, 1, "a_vault");
    addv(0, 4'b0000, 0, 1, "a_vault_hold");
    addv(0, 4'b1111, 0, 1, "a_vault_all");
    // No sword -> graveyard
    addv(1, 4'b0000, 0, 0, "reset_b");
    addv(0, 4'b0010, 0, 0, "b_tunnel");
    addv(0, 4'b0100, 0, 0, "b_river");
    addv(0, 4'b0010, 0, 0, "b_den");
    addv(0, 4'b0000, 1, 0, "b_grave");
    addv(0, 4'b1000, 1, 0, "b_grave_n");
    addv(0, 4'b0100, 1, 0, "b_grave_s");
    addv(0, 4'b0010, 1, 0, "b_grave_e");
    addv(0, 4'b0001, 1, 0, "b_grave_w");
    // Invalid moves and priority; a stray den visit would surface as d=1
    addv(1, 4'b0000, 0, 0, "reset_c");
    addv(0, 4'b1000, 0, 0, "c_cave_n");
    addv(0, 4'b0100, 0, 0, "c_cave_s");
    addv(0, 4'b0001, 0, 0, "c_cave_w");
    addv(0, 4'b0010, 0, 0, "c_tunnel");
    addv(0, 4'b0100, 0, 0, "c_river");
    addv(0, 4'b1010, 0, 0, "c_prio_ne");
    addv(0, 4'b0000, 0, 0, "c_not_den");
    addv(0, 4'b0000, 0, 0, "c_still");
    addv(0, 4'b0100, 0, 0, "c_river2");
    addv(0, 4'b0010, 0, 0, "c_den");
    addv(0, 4'b0000, 1, 0, "c_grave");
    // Sword collected, then reset clears it
    addv(1, 4'b0000, 0, 0, "reset_d");
    addv(0, 4'b0010, 0, 0, "d_tunnel");
    addv(0, 4'b0100, 0, 0, "d_river");
    addv(0, 4'b0001, 0, 0, "d_stash");
    addv(0, 4'b0010, 0, 0, "d_river2");
    addv(0, 4'b1000, 0, 0, "d_tunnel2");
    addv(0, 4'b0001, 0, 0, "d_cave");
    addv(1, 4'b0000, 0, 0, "d_midreset");
    addv(0, 4'b0010, 0, 0, "d_tunnel3");
    addv(0, 4'b0100, 0, 0, "d_river3");
    addv(0, 4'b0010, 0, 0, "d_den");
    addv(0, 4'b0000, 1, 0, "d_grave_nosword");

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      else step(vecs[i].dirs);
      check(vecs[i].name, d, win, vecs[i].exp_d, vecs[i].exp_win);
    end

    // Async reset while in VAULT: win must drop before the next edge
    do_reset();
    step(4'b0010); step(4'b0100); step(4'b0001);
    step(4'b0010); step(4'b0010); step(4'b0010);
    check("async_pre_vault", d, win, 1'b0, 1'b1);
    @(posedge clk);
    #3 reset = 1'b1;
    #1 check("async_reset_drop", d, win, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    check("async_reset_release", d, win, 1'b0, 1'b0);

    // Randomized walks against the reference model
    for (int ep = 0; ep < 60; ep++) begin
      do_reset();
      m_room = 0; m_sword = 0;
      check("rand_reset", d, win, 1'b0, 1'b0);
      for (int k = 0; k < 25; k++) begin
        logic [3:0] dv;
        int nr;
        dv = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 49) == 0) begin
          do_reset();
          m_room = 0; m_sword = 0;
        end else begin
          step(dv);
          nr = model_next(m_room, m_sword, dv);
          if (m_room == 3) m_sword = 1;
          m_room = nr;
        end
        check("rand_walk", d, win, logic'(m_room == 6), logic'(m_room == 5));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
